// File: rtl/rhd_sequencer_pkg.sv
// Shared definitions for the RHD2164 command sequencer.
// Contents: FSM state enum, RHD command opcodes, aux register addresses,
// timer width, and the helper that maps the slot a word arrives in to the
// slot whose command produced it.
package rhd_sequencer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CS_SETUP,
    ST_START,
    ST_WAIT_XFER,
    ST_CS_HIGH
  } seq_state_t;

  localparam logic [1:0] OP_CONVERT = 2'b00;
  localparam logic [1:0] OP_READ    = 2'b11;

  localparam logic [5:0] AUX_REG_0 = 6'd40;
  localparam logic [5:0] AUX_REG_1 = 6'd41;
  localparam logic [5:0] AUX_REG_2 = 6'd42;

  localparam int TIMER_W = 16;

  // The master's done flag is still high for a couple of cycles after start.
  localparam int XFER_IGNORE_CLKS = 2;

  // The chip answers two commands late: a word received in slot s belongs to
  // slot (s - 2) mod frame_len. frame_len <= 67, so slot + frame_len fits in 7 bits.
  function automatic logic [6:0] result_tag(input logic [6:0] slot,
                                            input logic [6:0] frame_len);
    if (slot >= 7'd2) result_tag = slot - 7'd2;
    else              result_tag = slot + frame_len - 7'd2;
  endfunction

endpackage

// File: rtl/rhd_cmd_rom.sv
// Slot -> RHD2164 command word lookup.
// Ports:
//   slot  in  7   frame slot index (0..NUM_CH+2)
//   word  out 16  CONVERT(slot) for channel slots, READ(40/41/42) for the
//                 three trailing aux slots
module rhd_cmd_rom
  import rhd_sequencer_pkg::*;
#(
  parameter int NUM_CH = 32
) (
  input  logic [6:0]  slot,
  output logic [15:0] word
);

  always_comb begin
    word = 16'h0000;
    if (slot < 7'(NUM_CH))
      word = {OP_CONVERT, slot[5:0], 8'h00};
    else if (slot == 7'(NUM_CH))
      word = {OP_READ, AUX_REG_0, 8'h00};
    else if (slot == 7'(NUM_CH + 1))
      word = {OP_READ, AUX_REG_1, 8'h00};
    else
      word = {OP_READ, AUX_REG_2, 8'h00};
  end

endmodule

// File: rtl/rhd_sequencer.sv
// RHD2164 frame sequencer: walks NUM_CH CONVERT slots plus three aux READ
// slots, framing each 16-bit SPI word with chip select, and re-tags the
// pipelined results coming back on MISO.
// Ports:
//   i_clk           in   1   clock, rising edge
//   i_rst           in   1   synchronous reset, active low
//   i_enable        in   1   1 = run frames, 0 = stop after the word in flight
//   o_spi_din       out  16  command word to SPI master
//   o_spi_start     out  1   one-cycle start pulse to SPI master
//   i_spi_done      in   1   SPI master idle/ready
//   i_spi_rx_done   in   1   received-word-valid pulse
//   i_spi_dout      in   16  received word
//   o_cs_n          out  1   chip select, active low
//   o_sample_valid  out  1   qualifies o_sample / o_sample_tag
//   o_sample        out  16  captured result word
//   o_sample_tag    out  7   slot that produced o_sample
//   o_frame_start   out  1   pulse when slot 0 is issued
//   o_busy          out  1   high outside IDLE
//
// state        | meaning
// ST_IDLE      | cs_n high, waiting for enable and an idle SPI master
// ST_CS_SETUP  | cs_n low, counting CS_SETUP_CLKS before start
// ST_START     | one-cycle start pulse with the slot's command word
// ST_WAIT_XFER | word on the wire; done ignored for the first 2 cycles
// ST_CS_HIGH   | cs_n high for CS_HIGH_CLKS, then next slot or IDLE
module rhd_sequencer
  import rhd_sequencer_pkg::*;
#(
  parameter int NUM_CH        = 32,
  parameter int CS_SETUP_CLKS = 4,
  parameter int CS_HIGH_CLKS  = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_enable,
  output logic [15:0] o_spi_din,
  output logic        o_spi_start,
  input  logic        i_spi_done,
  input  logic        i_spi_rx_done,
  input  logic [15:0] i_spi_dout,
  output logic        o_cs_n,
  output logic        o_sample_valid,
  output logic [15:0] o_sample,
  output logic [6:0]  o_sample_tag,
  output logic        o_frame_start,
  output logic        o_busy
);

  localparam logic [6:0]         LAST_SLOT   = 7'(NUM_CH + 2);
  localparam logic [6:0]         FRAME_LEN   = 7'(NUM_CH + 3);
  localparam logic [TIMER_W-1:0] SETUP_LOAD  = TIMER_W'(CS_SETUP_CLKS - 1);
  localparam logic [TIMER_W-1:0] HIGH_LOAD   = TIMER_W'(CS_HIGH_CLKS - 1);
  localparam logic [TIMER_W-1:0] IGNORE_LOAD = TIMER_W'(XFER_IGNORE_CLKS);

  seq_state_t         state;
  logic [6:0]         slot;
  logic [TIMER_W-1:0] timer;
  logic [1:0]         discard;
  logic [15:0]        slot_word;

  rhd_cmd_rom #(.NUM_CH(NUM_CH)) u_cmd_rom (
    .slot (slot),
    .word (slot_word)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state          <= ST_IDLE;
      slot           <= 7'd0;
      timer          <= '0;
      discard        <= 2'd2;
      o_cs_n         <= 1'b1;
      o_spi_start    <= 1'b0;
      o_spi_din      <= 16'h0000;
      o_sample_valid <= 1'b0;
      o_sample       <= 16'h0000;
      o_sample_tag   <= 7'd0;
      o_frame_start  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_spi_start    <= 1'b0;
      o_frame_start  <= 1'b0;
      o_sample_valid <= 1'b0;

      // Results are only trusted while a word is actually on the wire; the
      // first two after leaving IDLE answer commands never sent this run.
      if (state == ST_WAIT_XFER && i_spi_rx_done) begin
        if (discard != 2'd0) begin
          discard <= discard - 2'd1;
        end else begin
          o_sample       <= i_spi_dout;
          o_sample_tag   <= result_tag(slot, FRAME_LEN);
          o_sample_valid <= 1'b1;
        end
      end

      case (state)
        ST_IDLE: begin
          if (i_enable && i_spi_done) begin
            state   <= ST_CS_SETUP;
            o_cs_n  <= 1'b0;
            o_busy  <= 1'b1;
            slot    <= 7'd0;
            discard <= 2'd2;
            timer   <= SETUP_LOAD;
          end
        end
        ST_CS_SETUP: begin
          if (timer == '0) begin
            state         <= ST_START;
            o_spi_start   <= 1'b1;
            o_spi_din     <= slot_word;
            o_frame_start <= (slot == 7'd0);
          end else begin
            timer <= timer - 1'b1;
          end
        end
        ST_START: begin
          state <= ST_WAIT_XFER;
          timer <= IGNORE_LOAD;
        end
        ST_WAIT_XFER: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (i_spi_done) begin
            state  <= ST_CS_HIGH;
            o_cs_n <= 1'b1;
            timer  <= HIGH_LOAD;
          end
        end
        ST_CS_HIGH: begin
          if (timer != '0) begin
            timer <= timer - 1'b1;
          end else if (i_enable) begin
            state  <= ST_CS_SETUP;
            o_cs_n <= 1'b0;
            slot   <= (slot == LAST_SLOT) ? 7'd0 : slot + 7'd1;
            timer  <= SETUP_LOAD;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_cs_n <= 1'b1;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/rhd_sequencer.md
RHD_SEQUENCER -- requirements
Module: rhd_sequencer

Interface
REQ-001 SHALL have parameter NUM_CH, default 32: CONVERT commands per frame, range 1..64.
REQ-002 SHALL have parameter CS_SETUP_CLKS, default 4: i_clk cycles from o_cs_n falling to o_spi_start, minimum 1.
REQ-003 SHALL have parameter CS_HIGH_CLKS, default 8: minimum i_clk cycles o_cs_n is held high between words, minimum 1.
REQ-004 SHALL have port i_clk, in, 1: single clock; all logic runs on its rising edge.
REQ-005 SHALL have port i_rst, in, 1: synchronous, active-low reset.
REQ-006 SHALL have port i_enable, in, 1: level; 1 runs continuous frames, 0 requests a stop.
REQ-007 SHALL have port o_spi_din, out, 16: command word presented to the SPI master.
REQ-008 SHALL have port o_spi_start, out, 1: one-cycle start pulse to the SPI master.
REQ-009 SHALL have port i_spi_done, in, 1: SPI master idle/ready.
REQ-010 SHALL have port i_spi_rx_done, in, 1: one-cycle received-word-valid pulse.
REQ-011 SHALL have port i_spi_dout, in, 16: received MISO word.
REQ-012 SHALL have port o_cs_n, out, 1: chip select to the RHD2164, active-low.
REQ-013 SHALL have port o_sample_valid, out, 1: one-cycle pulse qualifying o_sample and o_sample_tag.
REQ-014 SHALL have port o_sample, out, 16: captured result word.
REQ-015 SHALL have port o_sample_tag, out, 7: slot index (0..NUM_CH+2) of the command that produced o_sample.
REQ-016 SHALL have port o_frame_start, out, 1: one-cycle pulse when slot 0 is issued.
REQ-017 SHALL have port o_busy, out, 1: high in every state except IDLE.

Function
REQ-018 Frame SHALL be NUM_CH+3 slots: slots 0..NUM_CH-1 are CONVERT(ch) = {2'b00, ch[5:0], 8'h00}; slots NUM_CH..NUM_CH+2 are READ(40/41/42) = {2'b11, reg[5:0], 8'h00}.
REQ-019 FSM states SHALL be IDLE, CS_SETUP, START, WAIT_XFER, CS_HIGH.
REQ-020 IDLE -> CS_SETUP SHALL occur when i_enable=1 and i_spi_done=1; the transition drives o_cs_n=0 and resets the slot counter to 0.
REQ-021 CS_SETUP SHALL hold for CS_SETUP_CLKS cycles, then go to START.
REQ-022 START SHALL last 1 cycle: o_spi_start=1, o_spi_din = word of the current slot (held stable until the next START); o_frame_start=1 if slot=0.
REQ-023 WAIT_XFER SHALL ignore i_spi_done for the first 2 cycles (the master's done deasserts late), then exit when i_spi_done=1.
REQ-024 On WAIT_XFER exit, o_cs_n SHALL rise and the FSM SHALL enter CS_HIGH for CS_HIGH_CLKS cycles.
REQ-025 CS_HIGH exit: if i_enable=1, SHALL increment the slot with wrap NUM_CH+2 -> 0 and go to CS_SETUP.
REQ-026 CS_HIGH exit: if i_enable=0, SHALL go to IDLE; i_enable is sampled only at this point, so a word in flight always completes.
REQ-027 Results SHALL follow the chip's 2-word pipeline: a word received in slot s SHALL be tagged (s-2) mod (NUM_CH+3).
REQ-028 The first 2 words received after leaving IDLE SHALL be discarded, with no o_sample_valid.
REQ-029 Otherwise, i_spi_rx_done=1 SHALL register i_spi_dout into o_sample and the tag into o_sample_tag, with o_sample_valid=1 on the next cycle; o_sample and o_sample_tag SHALL hold until the next valid.
REQ-030 An i_spi_rx_done outside WAIT_XFER SHALL be ignored.
REQ-031 The slot counter SHALL be 7 bits; tag arithmetic SHALL be modulo NUM_CH+3 without overflow for NUM_CH=64.

Reset
REQ-032 On i_rst=0 at a clock edge, the FSM SHALL enter IDLE and the following SHALL apply: o_cs_n=1, o_spi_start=0, o_spi_din=0, o_sample_valid=0, o_sample=0, o_sample_tag=0, o_frame_start=0, o_busy=0, slot=0, discard counter=2.
REQ-033 Reset mid-transfer SHALL raise o_cs_n on the same edge; the SPI master is reset from the same i_rst.

Structure
REQ-034 A shared package SHALL hold the state enum, the RHD command opcodes (CONVERT=2'b00, READ=2'b11) and the aux register addresses 40/41/42.
REQ-035 The SPI master SHALL be instantiated at the level above; rhd_sequencer SHALL have no sub-module except an optional rhd_cmd_rom (slot -> command word).

Verification
REQ-036 Bench SHALL cover, with NUM_CH=4 and an SPI master model: i_enable=1 -> o_spi_din sequence 0x0000, 0x0100, 0x0200, 0x0300, 0xE800, 0xE900, 0xEA00, then 0x0000; o_frame_start on every 7th start.
REQ-037 Bench SHALL cover the MISO model returning 0x1000+slot -> first valid o_sample=0x1000 with tag 0, arriving in slot 2; no valid during slots 0-1.
REQ-038 Bench SHALL cover i_enable dropped in mid-WAIT_XFER of slot 5 -> slot 5 completes, o_cs_n high, IDLE after CS_HIGH_CLKS, no further starts.
REQ-039 Bench SHALL cover i_rst=0 two cycles after START -> o_cs_n=1 and o_busy=0 on that edge; re-enable -> first command 0x0000 and discard of 2 words again.
REQ-040 Bench SHALL cover the cycle checks: o_cs_n low to o_spi_start = CS_SETUP_CLKS cycles; o_cs_n high time >= CS_HIGH_CLKS cycles.
REQ-041 Bench SHALL cover a spurious i_spi_rx_done during CS_HIGH -> no o_sample_valid.
